shared_reg_arbiter: RTL and testbench

//  Round-robin arbiter that shares one WIDTH-bit enabled register (flopenr-style) among N_REQ requesters.

---
 rtl/shared_arb_pkg.sv | 19 +
 rtl/shared_reg_arbiter_rr_pick.sv | 47 ++++
 rtl/shared_reg_arbiter.sv | 150 +++++++++++++++
 tb/tb_shared_reg_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shared_arb_pkg.sv
// ---------------------------------------------------------------------------
// shared_arb_pkg
//   Shared types and helpers for the shared-register round-robin arbiter.
//   - arb_state_t : arbiter FSM state (IDLE / OWN)
//   - clog2_min1  : $clog2 clamped to at least 1 bit, so index and counter
//                   vectors never collapse to zero width.
// ---------------------------------------------------------------------------
package shared_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans req starting at ptr+1 and
//   wrapping, and returns the first set bit.
// Ports
//   req    in   N_REQ   candidate request vector
//   ptr    in   IDX_W   last winner; the search starts just above it
//   valid  out  1       at least one candidate found
//   onehot out  N_REQ   one-hot winner (all zero when !valid)
//   idx    out  IDX_W   binary winner index (0 when !valid)
// ---------------------------------------------------------------------------
module rr_pick
  import shared_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  cand;
    logic found;
    // NOTE: every output and temporary gets a default before the search
    // loop; a path that skips an assignment would otherwise infer a latch.
    valid  = 1'b0;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    // Offsets 1..N_REQ visit every requester once, with ptr itself last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
      end
    end
    valid = found;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter
//   Round-robin arbiter owning one WIDTH-bit enabled register shared by
//   N_REQ requesters. One requester owns the register at a time; its write
//   data is steered onto the register while it keeps requesting. A tenure
//   is capped at MAX_HOLD cycles when someone else is waiting.
// Ports
//   clk    in   1            clock
//   reset  in   1            synchronous, active-high reset
//   req    in   N_REQ        level requests
//   wdata  in   N_REQ*WIDTH  flattened write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    out  N_REQ        registered one-hot grant, zero when idle
//   owner  out  IDX_W        current owner index, zero when idle
//   busy   out  1            a grant is active
//   q      out  WIDTH        shared register contents
// ---------------------------------------------------------------------------
module shared_reg_arbiter
  import shared_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int WIDTH    = 32,
  parameter  int MAX_HOLD = 8,
  localparam int IDX_W    = clog2_min1(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       q
);

  localparam int HOLD_W = clog2_min1(MAX_HOLD + 1);

  arb_state_t        state,    state_n;
  logic [N_REQ-1:0]  gnt_n;
  logic [IDX_W-1:0]  owner_n;
  logic [IDX_W-1:0]  rr_ptr,   rr_ptr_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;

  logic              pick_valid;
  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;

  logic              owner_req;
  logic              hold_full;
  logic              reg_en;
  logic [WIDTH-1:0]  sel_data;

  // gnt is zero in IDLE, so masking it out gives the plain request vector
  // for the idle pick and the "everyone but the owner" vector for handoff.
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req & ~gnt),
    .ptr    (rr_ptr),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  assign owner_req = req[owner];
  assign hold_full = (hold_cnt == HOLD_W'(MAX_HOLD));
  assign reg_en    = (state == OWN) && gnt[owner] && owner_req;
  assign busy      = (state == OWN);

  // Only the owner's slice is ever selected, so X on other slices cannot
  // reach q.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IDX_W'(i)) sel_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Next-state / next-grant logic.
  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    hold_n   = hold_cnt;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n  = OWN;
          gnt_n    = pick_onehot;
          owner_n  = pick_idx;
          rr_ptr_n = pick_idx;
          hold_n   = HOLD_W'(1);
        end
      end
      OWN: begin
        if (!owner_req || hold_full) begin
          if (pick_valid) begin
            // Zero-bubble handoff to the next waiting requester.
            gnt_n    = pick_onehot;
            owner_n  = pick_idx;
            rr_ptr_n = pick_idx;
            hold_n   = HOLD_W'(1);
          end else if (owner_req) begin
            // Hold expired but nobody else wants it: start a fresh tenure.
            hold_n = HOLD_W'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            owner_n = '0;
            hold_n  = '0;
          end
        end else if (!hold_full) begin
          hold_n = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        owner_n = '0;
        hold_n  = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= IDX_W'(N_REQ - 1);
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      hold_cnt <= hold_n;
    end
  end

  // Shared enabled register; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)       q <= '0;
    else if (reg_en) q <= sel_data;
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_busy_gnt:   assert property (@(posedge clk) disable iff (reset) busy == (gnt != '0));

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_reg_arbiter
//   Directed bench for shared_reg_arbiter (N_REQ=4, WIDTH=32, MAX_HOLD=8)
//   with hand-computed expectations, followed by a random soak that checks
//   grant one-hotness, busy consistency and that q never goes unknown.
// ---------------------------------------------------------------------------
module tb_shared_reg_arbiter;

  localparam int N_REQ    = 4;
  localparam int WIDTH    = 32;
  localparam int MAX_HOLD = 8;
  localparam int IDX_W    = 2;

  logic                   clk;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [IDX_W-1:0]       owner;
  logic                   busy;
  logic [WIDTH-1:0]       q;

  int total = 0;
  int bad   = 0;

  shared_reg_arbiter #(
    .N_REQ    (N_REQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int          viol;
    logic [31:0] v;

    reset = 1'b1;
    req   = '0;
    wdata = '0;
    do_reset();

    // Reset state.
    check("rst_gnt",   64'(gnt),   64'h0);
    check("rst_owner", 64'(owner), 64'h0);
    check("rst_busy",  64'(busy),  64'h0);
    check("rst_q",     64'(q),     64'h0);

    // Single requester.
    wdata[2*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
    req = 4'b0100;
    step();
    check("single_gnt",   64'(gnt),   64'h4);
    check("single_owner", 64'(owner), 64'h2);
    check("single_busy",  64'(busy),  64'h1);
    check("single_q0",    64'(q),     64'h0);
    step();
    check("single_q",     64'(q),     64'hDEAD_BEEF);
    req = 4'b0000;
    step();
    check("single_busy_drop", 64'(busy), 64'h0);
    check("single_gnt_drop",  64'(gnt),  64'h0);
    check("single_owner_idle", 64'(owner), 64'h0);
    check("single_q_keep",    64'(q),    64'hDEAD_BEEF);

    // Simultaneous requests from reset, each owner holds for 2 cycles.
    do_reset();
    for (int i = 0; i < N_REQ; i++) wdata[i*WIDTH +: WIDTH] = 32'hA000_0000 | 32'(i);
    req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) begin
      step();
      check($sformatf("rr_gnt_%0d", i),   64'(gnt),   64'(4'b0001 << i));
      check($sformatf("rr_owner_%0d", i), 64'(owner), 64'(i));
      check($sformatf("rr_qprev_%0d", i), 64'(q),
            (i == 0) ? 64'h0 : 64'(32'hA000_0000 | 32'(i - 1)));
      step();
      check($sformatf("rr_hold_%0d", i), 64'(gnt), 64'(4'b0001 << i));
      check($sformatf("rr_q_%0d", i),    64'(q),   64'(32'hA000_0000 | 32'(i)));
      req[i] = 1'b0;
    end
    step();
    check("rr_idle", 64'(gnt), 64'h0);

    // Starvation bound: requester 1 holds, requester 3 arrives at cycle 3.
    do_reset();
    req = 4'b0010;
    step();
    check("starve_gnt_1", 64'(gnt), 64'h2);
    for (int c = 2; c <= MAX_HOLD; c++) begin
      if (c == 3) req = 4'b1010;
      step();
      check($sformatf("starve_gnt_%0d", c), 64'(gnt), 64'h2);
    end
    step();
    check("starve_handoff",       64'(gnt),   64'h8);
    check("starve_handoff_owner", 64'(owner), 64'h3);
    check("starve_handoff_busy",  64'(busy),  64'h1);

    // Hold expiry with no contention: grant stays, q follows every cycle.
    do_reset();
    req = 4'b0001;
    step();
    check("solo_gnt_first", 64'(gnt), 64'h1);
    for (int c = 0; c < 20; c++) begin
      v = 32'h5000_0000 + 32'(c * 3 + 1);
      wdata[0 +: WIDTH] = v;
      step();
      check($sformatf("solo_gnt_%0d", c), 64'(gnt), 64'h1);
      check($sformatf("solo_q_%0d", c),   64'(q),   64'(v));
    end
    req = '0;
    step();

    // Reset mid-tenure.
    do_reset();
    wdata = '0;
    wdata[1*WIDTH +: WIDTH] = 32'h0000_1234;
    req = 4'b0010;
    step();
    check("mid_gnt_pre", 64'(gnt), 64'h2);
    step();
    check("mid_q_pre",   64'(q),   64'h1234);
    reset = 1'b1;
    wdata[1*WIDTH +: WIDTH] = 32'h0000_9999;
    step();
    check("mid_rst_gnt",   64'(gnt),   64'h0);
    check("mid_rst_owner", 64'(owner), 64'h0);
    check("mid_rst_busy",  64'(busy),  64'h0);
    check("mid_rst_q",     64'(q),     64'h0);
    reset = 1'b0;
    req = 4'b0110;
    step();
    check("mid_regrant_gnt",   64'(gnt),   64'h2);
    check("mid_regrant_owner", 64'(owner), 64'h1);

    // Non-owner isolation: X on requester 1's data while 0 owns.
    do_reset();
    wdata = '0;
    wdata[0 +: WIDTH]     = 32'hCAFE_0000;
    wdata[WIDTH +: WIDTH] = 'x;
    req = 4'b0011;
    step();
    check("iso_gnt", 64'(gnt), 64'h1);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("iso_q_%0d", c), 64'(q), 64'hCAFE_0000);
    end
    req = 4'b0000;
    step();
    check("iso_idle_q", 64'(q), 64'hCAFE_0000);

    // Random soak.
    do_reset();
    viol = 0;
    for (int c = 0; c < 10000; c++) begin
      req = N_REQ'($urandom);
      for (int i = 0; i < N_REQ; i++) wdata[i*WIDTH +: WIDTH] = $urandom;
      step();
      if (!$onehot0(gnt))        viol++;
      if (busy !== (gnt != '0))  viol++;
      if ($isunknown(q))         viol++;
      if (gnt != '0 && gnt[owner] !== 1'b1) viol++;
    end
    check("rand_violations", 64'(viol), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
